// File: rtl/smiley_hit_edge_detector_if.sv
// Pixel-stream and result bundle between the VGA pipeline and the smiley hit-edge detector.
// The master side drives the scan and drawing requests; the slave side returns the published frame result.
interface smiley_hit_edge_detector_if #(
  parameter int CNT_W = 8
);
  logic                startOfFrame;
  logic [10:0]         pixelX;
  logic [10:0]         pixelY;
  logic signed [10:0]  smileyTopLeftX;
  logic signed [10:0]  smileyTopLeftY;
  logic                smileyDR;
  logic                brickDR;
  logic                borderDR;
  logic                collision;
  logic [3:0]          HitEdgeCode;
  logic [CNT_W-1:0]    overlapCount;

  modport master (
    output startOfFrame, pixelX, pixelY, smileyTopLeftX, smileyTopLeftY,
           smileyDR, brickDR, borderDR,
    input  collision, HitEdgeCode, overlapCount
  );

  modport slave (
    input  startOfFrame, pixelX, pixelY, smileyTopLeftX, smileyTopLeftY,
           smileyDR, brickDR, borderDR,
    output collision, HitEdgeCode, overlapCount
  );
endinterface

// File: rtl/smiley_hit_edge_detector.sv
// Per-frame collision classifier: counts sprite/brick overlap pixels per sprite edge band during a
// frame and publishes which edges were hit, held stable for the whole following frame.
module smiley_hit_edge_detector #(
  parameter int OBJ_W      = 32,
  parameter int OBJ_H      = 32,
  parameter int EDGE_W     = 4,
  parameter int MIN_PIXELS = 2,
  parameter int CNT_W      = 8
) (
  input  logic                           clk,
  input  logic                           resetN,
  smiley_hit_edge_detector_if.slave      bus
);

  localparam int unsigned EDGE_BOTTOM = 0;
  localparam int unsigned EDGE_RIGHT  = 1;
  localparam int unsigned EDGE_TOP    = 2;
  localparam int unsigned EDGE_LEFT   = 3;

  localparam logic [11:0]      OBJ_W_L   = 12'(OBJ_W);
  localparam logic [11:0]      OBJ_H_L   = 12'(OBJ_H);
  localparam logic [11:0]      EDGE_W_L  = 12'(EDGE_W);
  localparam logic [11:0]      RIGHT_LO  = 12'(OBJ_W - EDGE_W);
  localparam logic [11:0]      BOTTOM_LO = 12'(OBJ_H - EDGE_W);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] MIN_CNT   = CNT_W'(MIN_PIXELS);

  typedef enum logic {
    WAIT_SOF,
    ACCUM
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] edge_cnt_q [4];
  logic [CNT_W-1:0] edge_cnt_d [4];
  logic [CNT_W-1:0] total_cnt_q, total_cnt_d;
  logic [3:0]       hit_edge_q, hit_edge_d;
  logic             collision_q, collision_d;
  logic [CNT_W-1:0] overlap_q, overlap_d;

  // Offsets are 12-bit two's complement; bit 11 set means the pixel lies left of / above the sprite.
  logic [11:0] off_x, off_y;
  logic        in_box;
  logic        overlap_px;
  logic [3:0]  band;

  assign off_x = {1'b0, bus.pixelX} - {bus.smileyTopLeftX[10], bus.smileyTopLeftX};
  assign off_y = {1'b0, bus.pixelY} - {bus.smileyTopLeftY[10], bus.smileyTopLeftY};

  // Drawing requests can lag a sprite move, so only overlaps inside the current box are trusted.
  assign in_box = !off_x[11] && (off_x < OBJ_W_L) &&
                  !off_y[11] && (off_y < OBJ_H_L);

  assign overlap_px = bus.smileyDR && (bus.brickDR || bus.borderDR) && in_box;

  assign band[EDGE_BOTTOM] = off_y >= BOTTOM_LO;
  assign band[EDGE_RIGHT]  = off_x >= RIGHT_LO;
  assign band[EDGE_TOP]    = off_y <  EDGE_W_L;
  assign band[EDGE_LEFT]   = off_x <  EDGE_W_L;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                               input logic             inc);
    return (inc && (value != CNT_MAX)) ? value + 1'b1 : value;
  endfunction

  // NOTE: every _d signal receives its hold value before any branch, so no path leaves one
  // unassigned and no latch can be inferred.
  always_comb begin
    state_d     = state_q;
    edge_cnt_d  = edge_cnt_q;
    total_cnt_d = total_cnt_q;
    hit_edge_d  = hit_edge_q;
    collision_d = collision_q;
    overlap_d   = overlap_q;

    unique case (state_q)
      WAIT_SOF: begin
        if (bus.startOfFrame) begin
          state_d     = ACCUM;
          total_cnt_d = '0;
          for (int i = 0; i < 4; i++) edge_cnt_d[i] = '0;
        end
      end

      ACCUM: begin
        if (bus.startOfFrame) begin
          // Close the finished frame and restart counting from zero on this same cycle.
          for (int i = 0; i < 4; i++) begin
            hit_edge_d[i] = edge_cnt_q[i] >= MIN_CNT;
            edge_cnt_d[i] = '0;
          end
          collision_d = |hit_edge_d;
          overlap_d   = total_cnt_q;
          total_cnt_d = '0;
        end

        // The pixel on the boundary cycle lands in the new frame's counters.
        total_cnt_d = sat_inc(total_cnt_d, overlap_px);
        for (int i = 0; i < 4; i++) begin
          edge_cnt_d[i] = sat_inc(edge_cnt_d[i], overlap_px && band[i]);
        end
      end

      default: state_d = WAIT_SOF;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the counters are a small array of flops, not a RAM, so they take the async reset
  // like the rest of the state; a mid-frame reset must discard any partial frame.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= WAIT_SOF;
      total_cnt_q <= '0;
      hit_edge_q  <= '0;
      collision_q <= 1'b0;
      overlap_q   <= '0;
      for (int i = 0; i < 4; i++) edge_cnt_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      total_cnt_q <= total_cnt_d;
      hit_edge_q  <= hit_edge_d;
      collision_q <= collision_d;
      overlap_q   <= overlap_d;
      for (int i = 0; i < 4; i++) edge_cnt_q[i] <= edge_cnt_d[i];
    end
  end

  assign bus.collision    = collision_q;
  assign bus.HitEdgeCode  = hit_edge_q;
  assign bus.overlapCount = overlap_q;

endmodule
